// File: rtl/n8_multi_pad_reader_if.sv
// Pad-bus and result signals of the multi-pad reader.
// The reader drives the shared latch/pulse lines, so it takes the master modport.
interface n8_multi_pad_reader_if #(
    parameter int NUM_PADS = 2,
    parameter int NUM_BITS = 8
);
    logic                         enable;
    logic [NUM_PADS-1:0]          data_in;
    logic                         latch;
    logic                         pulse;
    logic [NUM_PADS*NUM_BITS-1:0] buttons;
    logic                         valid;
    logic [NUM_PADS*NUM_BITS-1:0] pressed;
    logic [NUM_PADS*NUM_BITS-1:0] released;

    modport master (
        input  enable, data_in,
        output latch, pulse, buttons, valid, pressed, released
    );

    modport slave (
        output enable, data_in,
        input  latch, pulse, buttons, valid, pressed, released
    );
endinterface

// File: rtl/n8_multi_pad_reader.sv
// Polls NUM_PADS serial game pads on a shared latch/pulse pair and publishes
// per-frame button vectors with pressed/released edge masks.
module n8_multi_pad_reader #(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 8,
    parameter int DIV         = 131072,
    parameter int LATCH_TICKS = 2,
    parameter int GAP_TICKS   = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    n8_multi_pad_reader_if.master pad_if
);
    localparam int DIV_W   = $clog2(DIV);
    localparam int IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int CNT_MAX = (LATCH_TICKS > GAP_TICKS) ? LATCH_TICKS : GAP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE, GAP} state_t;

    state_t                             state, state_nxt;
    logic [DIV_W-1:0]                   div_cnt;
    logic                               tick;
    logic [CNT_W-1:0]                   cnt, cnt_nxt;
    logic [IDX_W-1:0]                   idx, idx_nxt, sample_idx;
    logic                               latch_nxt, pulse_nxt, sample, done;
    logic [NUM_PADS-1:0]                sync_p0, sync_p1;
    logic [NUM_BITS-1:0]                onehot;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  shift_q, shift_nxt;

    // Free-running tick divider, independent of the FSM state
    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) div_cnt <= '0;
        else               div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= pad_if.data_in;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        latch_nxt  = pad_if.latch;
        pulse_nxt  = pad_if.pulse;
        sample     = 1'b0;
        sample_idx = idx;
        done       = 1'b0;
        unique case (state)
            IDLE: if (tick && pad_if.enable) begin
                state_nxt = LATCH;
                latch_nxt = 1'b1;
                cnt_nxt   = '0;
            end
            LATCH: if (tick) begin
                if (cnt == CNT_W'(LATCH_TICKS - 1)) begin
                    latch_nxt  = 1'b0;
                    sample     = 1'b1;
                    sample_idx = '0;
                    cnt_nxt    = '0;
                    if (NUM_BITS == 1) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOW;
                        idx_nxt   = IDX_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LOW: if (tick) begin
                pulse_nxt = 1'b1;
                state_nxt = HIGH;
            end
            // Pads shift on the rising pulse; the bit is taken as the pulse falls
            HIGH: if (tick) begin
                pulse_nxt = 1'b0;
                sample    = 1'b1;
                if (idx == IDX_W'(NUM_BITS - 1)) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = LOW;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = GAP;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
            GAP: begin
                if (GAP_TICKS == 0) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (cnt == CNT_W'(GAP_TICKS - 1)) state_nxt = IDLE;
                    else                              cnt_nxt   = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign onehot = NUM_BITS'(1) << sample_idx;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        assign shift_nxt[p] = sample ? ((shift_q[p] & ~onehot) | ({NUM_BITS{sync_p1[p]}} & onehot))
                                     : shift_q[p];
    end

    // Result stage: buttons and edge masks become visible together with valid
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q         <= '1;
            pad_if.latch    <= 1'b0;
            pad_if.pulse    <= 1'b0;
            pad_if.valid    <= 1'b0;
            pad_if.buttons  <= '0;
            pad_if.pressed  <= '0;
            pad_if.released <= '0;
        end else begin
            shift_q      <= shift_nxt;
            pad_if.latch <= latch_nxt;
            pad_if.pulse <= pulse_nxt;
            pad_if.valid <= done;
            if (done) begin
                pad_if.buttons  <= ~shift_q;
                pad_if.pressed  <= ~shift_q & ~pad_if.buttons;
                pad_if.released <= shift_q & pad_if.buttons;
            end else begin
                pad_if.pressed  <= '0;
                pad_if.released <= '0;
            end
        end
    end
endmodule

// File: tb/tb_n8_multi_pad_reader.sv
// Bench for n8_multi_pad_reader: behavioural pad models plus a frame-level
// reference model for a 2x8 reader and a 1x12 reader.
module tb_n8_multi_pad_reader;
    localparam int DIV = 4;
    localparam int LT  = 2;
    localparam int GT  = 4;
    localparam int NP  = 2;
    localparam int NB  = 8;
    localparam int W   = NP * NB;
    localparam int NB2 = 12;
    localparam int GT2 = 1;

    logic clk = 1'b0;
    logic reset;
    logic rst_q;
    always #5 clk = ~clk;

    n8_multi_pad_reader_if #(.NUM_PADS(NP), .NUM_BITS(NB))  ifa ();
    n8_multi_pad_reader_if #(.NUM_PADS(1),  .NUM_BITS(NB2)) ifb ();

    n8_multi_pad_reader #(.NUM_PADS(NP), .NUM_BITS(NB), .DIV(DIV),
                          .LATCH_TICKS(LT), .GAP_TICKS(GT)) u_dut (
        .clk(clk), .reset(reset), .pad_if(ifa));

    n8_multi_pad_reader #(.NUM_PADS(1), .NUM_BITS(NB2), .DIV(DIV),
                          .LATCH_TICKS(LT), .GAP_TICKS(GT2)) u_dut12 (
        .clk(clk), .reset(reset), .pad_if(ifb));

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reset as seen by the DUT at the most recent rising edge
    always @(posedge clk) rst_q <= reset;

    // Pad A model and frame-level reference
    logic [W-1:0] mask_a = '0, frame_mask_a = '0, old_a = '0;
    int  pos_a = 0, lat_len_a = 0, pul_len_a = 0, npul_a = 0, latch_rises_a = 0, since_pf_a = 0;
    bit  frame_open_a = 0, lp_a = 0, pp_a = 0, armed_a = 0;

    always @(negedge clk) begin
        logic [W-1:0]  tmp;
        logic [NP-1:0] d;
        int bi;
        since_pf_a++;
        if (!ifa.enable) armed_a = 0;
        if (rst_q) begin
            check_eq("reset_outs_a", {ifa.latch, ifa.pulse, ifa.valid, ifa.buttons, ifa.pressed, ifa.released}, '0);
            old_a = '0; frame_open_a = 0; lat_len_a = 0; pul_len_a = 0; armed_a = 0;
        end else begin
            check_eq("latch_pulse_excl_a", ifa.latch & ifa.pulse, 0);
            if (ifa.latch && !lp_a) begin
                check_eq("prev_frame_closed_a", frame_open_a, 0);
                if (armed_a) check_eq("gap_len_a", since_pf_a, (GT + 1) * DIV);
                frame_open_a = 1; frame_mask_a = mask_a; pos_a = 0; npul_a = 0;
                latch_rises_a++; armed_a = 0;
            end
            if (ifa.latch) lat_len_a++;
            else if (lp_a) begin
                check_eq("latch_len_a", lat_len_a, LT * DIV);
                lat_len_a = 0;
            end
            if (ifa.pulse) begin
                pul_len_a++;
                if (!pp_a) begin npul_a++; pos_a++; end
            end else if (pp_a) begin
                check_eq("pulse_len_a", pul_len_a, DIV);
                pul_len_a = 0; since_pf_a = 0; armed_a = ifa.enable;
            end
            if (ifa.valid) begin
                check_eq("valid_in_frame_a", frame_open_a, 1);
                check_eq("npulse_a", npul_a, NB - 1);
                check_eq("buttons_a", ifa.buttons, frame_mask_a);
                check_eq("pressed_a", ifa.pressed, frame_mask_a & ~old_a);
                check_eq("released_a", ifa.released, ~frame_mask_a & old_a);
                old_a = frame_mask_a; frame_open_a = 0;
            end else begin
                check_eq("hold_a", {ifa.buttons, ifa.pressed, ifa.released}, {old_a, {W{1'b0}}, {W{1'b0}}});
            end
        end
        lp_a = ifa.latch; pp_a = ifa.pulse;
        bi = (pos_a < NB) ? pos_a : NB - 1;
        d = '0;
        for (int p = 0; p < NP; p++) begin
            tmp = frame_mask_a >> (p * NB + bi);
            d = {tmp[0], d[NP-1:1]};
        end
        ifa.data_in = reset ? NP'($urandom) : ~d;
    end

    // Pad B model and reference
    logic [NB2-1:0] mask_b = '0, frame_mask_b = '0, old_b = '0;
    int pos_b = 0, npul_b = 0;
    bit frame_open_b = 0, lp_b = 0, pp_b = 0;

    always @(negedge clk) begin
        logic [NB2-1:0] tmp;
        int bi;
        if (rst_q) begin
            old_b = '0; frame_open_b = 0;
        end else begin
            if (ifb.latch && !lp_b) begin
                frame_open_b = 1; frame_mask_b = mask_b; pos_b = 0; npul_b = 0;
            end
            if (ifb.pulse && !pp_b) begin npul_b++; pos_b++; end
            if (ifb.valid) begin
                check_eq("valid_in_frame_b", frame_open_b, 1);
                check_eq("npulse_b", npul_b, NB2 - 1);
                check_eq("buttons_b", ifb.buttons, frame_mask_b);
                check_eq("pressed_b", ifb.pressed, frame_mask_b & ~old_b);
                check_eq("released_b", ifb.released, ~frame_mask_b & old_b);
                old_b = frame_mask_b; frame_open_b = 0;
            end
        end
        lp_b = ifb.latch; pp_b = ifb.pulse;
        bi = (pos_b < NB2) ? pos_b : NB2 - 1;
        tmp = frame_mask_b >> bi;
        ifb.data_in = reset ? 1'($urandom) : ~tmp[0];
    end

    task automatic wait_valid_a(input string tag);
        int n = 0;
        @(negedge clk);
        while (!ifa.valid && n < 400) begin @(negedge clk); n++; end
        if (!ifa.valid) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_valid_b(input string tag);
        int n = 0;
        @(negedge clk);
        while (!ifb.valid && n < 400) begin @(negedge clk); n++; end
        if (!ifb.valid) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_pulse_a(input int which, input string tag);
        int n = 0;
        @(negedge clk);
        while (!(frame_open_a && ifa.pulse && npul_a == which) && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int saved;
        int n;
        logic [W-1:0] m;
        reset = 1'b1;
        ifa.enable = 1'b0;
        ifb.enable = 1'b0;
        mask_a = 16'h0081;
        repeat (5) begin
            @(posedge clk); #1;
            ifa.enable = 1'($urandom);
            ifb.enable = 1'($urandom);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        ifa.enable = 1'b1;
        ifb.enable = 1'b0;

        wait_valid_a("t2");
        check_eq("t2_buttons", ifa.buttons, 16'h0081);
        check_eq("t2_pressed", ifa.pressed, 16'h0081);
        check_eq("t2_released", ifa.released, 16'h0000);

        mask_a = 16'h0880;
        wait_valid_a("t3");
        check_eq("t3_buttons", ifa.buttons, 16'h0880);
        check_eq("t3_pressed", ifa.pressed, 16'h0800);
        check_eq("t3_released", ifa.released, 16'h0001);

        mask_a = W'($urandom);
        wait_pulse_a(3, "t4_pulse3");
        ifa.enable = 1'b0;
        wait_valid_a("t4");
        saved = latch_rises_a;
        repeat (120) @(negedge clk);
        check_eq("t4_no_restart", latch_rises_a, saved);
        check_eq("t4_latch_low", ifa.latch, 0);
        ifa.enable = 1'b1;
        n = 0;
        while (!ifa.latch && n < 50) begin @(negedge clk); n++; end
        check_eq("t4_restart", ifa.latch, 1);
        wait_valid_a("t4b");

        m = W'($urandom);
        mask_a = m;
        wait_pulse_a(4, "t5_pulse4");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_eq("t5_pulse_cleared", ifa.pulse, 0);
        check_eq("t5_buttons_cleared", ifa.buttons, 0);
        wait_valid_a("t5");
        check_eq("t5_buttons", ifa.buttons, m);
        check_eq("t5_pressed", ifa.pressed, m);

        for (int k = 0; k < 4; k++) begin
            mask_a = W'($urandom);
            wait_valid_a("rand_a");
        end

        mask_b = 12'hA05;
        ifb.enable = 1'b1;
        wait_valid_b("t6");
        check_eq("t6_buttons", ifb.buttons, 12'hA05);
        check_eq("t6_pressed", ifb.pressed, 12'hA05);
        for (int k = 0; k < 3; k++) begin
            mask_b = NB2'($urandom);
            wait_valid_b("rand_b");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
